// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and bus types for the byte-serial memory controller.
package mem_ctrl_pkg;

  // Data access size encodings driven by the MEM stage
  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_BUSY = 2'd1,
    MC_DONE = 2'd2
  } mc_state_e;

  typedef logic [31:0] mem_addr_bus_t;
  typedef logic [31:0] mem_data_bus_t;

  localparam mem_data_bus_t ZERO_WORD = 32'h0000_0000;

  // Number of bytes moved for a given size code; the unused code maps to a word
  function automatic logic [2:0] sel_len(input logic [1:0] sel);
    case (sel)
      MEM_BYTE: sel_len = 3'd1;
      MEM_HALF: sel_len = 3'd2;
      MEM_WORD: sel_len = 3'd4;
      default:  sel_len = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_lane_asm.sv
// Byte-lane assembler: collects RAM read bytes into a little-endian word.
// word_nxt already contains the byte arriving this cycle so the owner's
// output register can capture the complete word on the final BUSY edge.
module mem_ctrl_lane_asm
  import mem_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [2:0]      cnt,
  input  logic [7:0]      din,
  output logic [3:0][7:0] word_nxt
);

  logic [3:0][7:0] lanes;
  logic [1:0]      idx;

  // byte arriving now belongs to the address driven last cycle
  assign idx = 2'(cnt - 3'd1);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    // lane mux: take the incoming byte when this lane is addressed
    always_comb begin
      word_nxt[i] = lanes[i];
      if (en && (idx == 2'(i))) word_nxt[i] = din;
    end

    // lane register: cleared while idle so uncovered lanes read as zero
    always_ff @(posedge clk) begin
      if (!rst || clr) lanes[i] <= 8'h00;
      else             lanes[i] <= word_nxt[i];
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates IF fetches and MEM loads/stores
// onto one 8-bit RAM port with 1-cycle read latency. MEM has priority.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_cancel_i,
  output logic              if_done_o,
  output logic [31:0]       if_inst_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_sel_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic              mem_done_o,
  output logic [31:0]       mem_rdata_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_wr_o,
  output logic [7:0]        ram_dout_o,
  input  logic [7:0]        ram_din_i
);

  mc_state_e         state;
  logic [2:0]        cnt;
  logic [2:0]        len;
  logic              owner_if;
  logic              we;
  logic              cancel_flag;
  logic [ADDR_W-1:0] base;
  logic [3:0][7:0]   wdata;
  logic [3:0][7:0]   asm_word;
  logic              last;
  logic              asm_en;
  logic [2:0]        off;

  // reads need one extra cycle for the final byte to return
  assign last   = we ? (cnt == len - 3'd1) : (cnt == len);
  assign asm_en = (state == MC_BUSY) && !we && (cnt != 3'd0);
  // on the trailing read cycle the address holds at the last byte
  assign off    = (cnt == len) ? len - 3'd1 : cnt;

  // RAM port drive; write strobe is gated by reset so an abort never writes
  always_comb begin
    ram_addr_o = '0;
    ram_dout_o = 8'h00;
    ram_wr_o   = 1'b0;
    if (state == MC_BUSY) begin
      ram_addr_o = base + ADDR_W'(off);
      if (we) begin
        ram_dout_o = wdata[cnt[1:0]];
        ram_wr_o   = rst;
      end
    end
  end

  mem_ctrl_lane_asm u_lane_asm (
    .clk      (clk),
    .rst      (rst),
    .clr      (state == MC_IDLE),
    .en       (asm_en),
    .cnt      (cnt),
    .din      (ram_din_i),
    .word_nxt (asm_word)
  );

  // controller FSM with registered done pulses and result words
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= MC_IDLE;
      cnt         <= 3'd0;
      len         <= 3'd0;
      owner_if    <= 1'b0;
      we          <= 1'b0;
      cancel_flag <= 1'b0;
      base        <= '0;
      wdata       <= ZERO_WORD;
      if_done_o   <= 1'b0;
      mem_done_o  <= 1'b0;
      if_inst_o   <= ZERO_WORD;
      mem_rdata_o <= ZERO_WORD;
    end else begin
      if_done_o  <= 1'b0;
      mem_done_o <= 1'b0;
      case (state)
        MC_IDLE: begin
          cnt         <= 3'd0;
          cancel_flag <= 1'b0;
          if (mem_req_i) begin
            owner_if <= 1'b0;
            base     <= mem_addr_i;
            len      <= sel_len(mem_sel_i);
            we       <= mem_we_i;
            wdata    <= mem_wdata_i;
            state    <= MC_BUSY;
          end else if (if_req_i && !if_cancel_i) begin
            owner_if <= 1'b1;
            base     <= if_addr_i;
            len      <= 3'd4;
            we       <= 1'b0;
            state    <= MC_BUSY;
          end
        end
        MC_BUSY: begin
          if (owner_if && if_cancel_i) cancel_flag <= 1'b1;
          if (last) begin
            state <= MC_DONE;
            if (owner_if) begin
              // a flushed fetch finishes its bus sequence silently
              if (!(cancel_flag || if_cancel_i)) begin
                if_done_o <= 1'b1;
                if_inst_o <= asm_word;
              end
            end else begin
              mem_done_o <= 1'b1;
              if (!we) mem_rdata_o <= asm_word;
            end
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        MC_DONE: begin
          cancel_flag <= 1'b0;
          state       <= MC_IDLE;
        end
        default: state <= MC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus random traffic
// checked against a byte-array memory model and cycle-count rules.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_cancel_i = 1'b0;
  logic        if_done_o;
  logic [31:0] if_inst_o;
  logic        mem_req_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [1:0]  mem_sel_i = 2'b00;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_wdata_i = '0;
  logic        mem_done_o;
  logic [31:0] mem_rdata_o;
  logic [31:0] ram_addr_o;
  logic        ram_wr_o;
  logic [7:0]  ram_dout_o;
  logic [7:0]  ram_din_i = 8'h00;

  int errors = 0;
  int checks = 0;

  logic [7:0]  ram     [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [31:0] obs_addr [0:20];
  logic        obs_wr   [0:20];
  logic [7:0]  obs_dout [0:20];

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_cancel_i(if_cancel_i),
    .if_done_o(if_done_o), .if_inst_o(if_inst_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_done_o(mem_done_o), .mem_rdata_o(mem_rdata_o),
    .ram_addr_o(ram_addr_o), .ram_wr_o(ram_wr_o), .ram_dout_o(ram_dout_o),
    .ram_din_i(ram_din_i)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic int nbytes(input logic [1:0] sel);
    if (sel == MEM_BYTE) return 1;
    if (sel == MEM_HALF) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
    logic [31:0] w = 32'h0;
    for (int i = 0; i < n; i++) w = w | (32'(ref_rd(a + 32'(i))) << (8 * i));
    return w;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    ram[a] = d;
    ref_mem[a] = d;
  endtask

  // synchronous RAM: write on strobe, read data one cycle after address
  always @(posedge clk) begin
    if (ram_wr_o) ram[ram_addr_o] = ram_dout_o;
    ram_din_i <= ram_rd(ram_addr_o);
  end

  // one request from C0 until its done pulse; captures bus activity per cycle
  task automatic run_access(input bit is_if, input bit we, input logic [1:0] sel,
                            input logic [31:0] addr, input logic [31:0] wd,
                            output int dcyc, output logic [31:0] data);
    @(negedge clk);
    if (is_if) begin
      if_req_i = 1'b1; if_addr_i = addr;
    end else begin
      mem_req_i = 1'b1; mem_we_i = we; mem_sel_i = sel;
      mem_addr_i = addr; mem_wdata_i = wd;
    end
    dcyc = -1;
    data = '0;
    for (int k = 1; k <= 16 && dcyc < 0; k++) begin
      @(negedge clk);
      obs_addr[k] = ram_addr_o; obs_wr[k] = ram_wr_o; obs_dout[k] = ram_dout_o;
      if (is_if ? if_done_o : mem_done_o) begin
        dcyc = k;
        data = is_if ? if_inst_o : mem_rdata_o;
        if_req_i = 1'b0; mem_req_i = 1'b0;
      end
    end
    if_req_i = 1'b0;
    mem_req_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (if_done_o !== 1'b0) begin errors++; $display("FAIL reset_if_done got=%b exp=0", if_done_o); end
    checks++; if (mem_done_o !== 1'b0) begin errors++; $display("FAIL reset_mem_done got=%b exp=0", mem_done_o); end
    checks++; if (ram_wr_o !== 1'b0) begin errors++; $display("FAIL reset_ram_wr got=%b exp=0", ram_wr_o); end
    checks++; if (if_inst_o !== 32'h0) begin errors++; $display("FAIL reset_if_inst got=%h exp=0", if_inst_o); end
    checks++; if (mem_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_mem_rdata got=%h exp=0", mem_rdata_o); end
    checks++; if (ram_addr_o !== 32'h0 || ram_dout_o !== 8'h0) begin
      errors++; $display("FAIL reset_ram_bus got addr=%h dout=%h exp 0/0", ram_addr_o, ram_dout_o);
    end
  endtask

  task automatic test_fetch();
    int dc; logic [31:0] d;
    preload(32'h100, 8'h13); preload(32'h101, 8'h05);
    preload(32'h102, 8'h10); preload(32'h103, 8'h00);
    run_access(1'b1, 1'b0, MEM_WORD, 32'h100, 32'h0, dc, d);
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (obs_addr[k] !== 32'h100 + 32'(k - 1) || obs_wr[k] !== 1'b0) begin
        errors++; $display("FAIL fetch_addr C%0d got=%h wr=%b exp=%h wr=0", k, obs_addr[k], obs_wr[k], 32'h100 + 32'(k - 1));
      end
    end
    checks++; if (dc != 6) begin errors++; $display("FAIL fetch_latency got=C%0d exp=C6", dc); end
    checks++; if (d !== 32'h0010_0513) begin errors++; $display("FAIL fetch_inst got=%h exp=00100513", d); end
    @(negedge clk);
    checks++; if (if_done_o !== 1'b0) begin errors++; $display("FAIL fetch_done_pulse got=%b exp=0", if_done_o); end
    checks++; if (if_inst_o !== 32'h0010_0513) begin errors++; $display("FAIL fetch_inst_hold got=%h exp=00100513", if_inst_o); end
  endtask

  task automatic test_sw();
    int dc; logic [31:0] d;
    logic [31:0] wd = 32'hDEAD_BEEF;
    run_access(1'b0, 1'b1, MEM_WORD, 32'h2000, wd, dc, d);
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (obs_wr[k] !== 1'b1 || obs_addr[k] !== 32'h2000 + 32'(k - 1) || obs_dout[k] !== wd[8*(k-1) +: 8]) begin
        errors++; $display("FAIL sw_bus C%0d got wr=%b addr=%h dout=%h exp wr=1 addr=%h dout=%h",
                           k, obs_wr[k], obs_addr[k], obs_dout[k], 32'h2000 + 32'(k - 1), wd[8*(k-1) +: 8]);
      end
      ref_mem[32'h2000 + 32'(k - 1)] = wd[8*(k-1) +: 8];
    end
    checks++; if (dc != 5) begin errors++; $display("FAIL sw_latency got=C%0d exp=C5", dc); end
    checks++; if (obs_wr[5] !== 1'b0) begin errors++; $display("FAIL sw_wr_in_done got=%b exp=0", obs_wr[5]); end
    checks++; if (ram_rd(32'h2003) !== 8'hDE || ram_rd(32'h2000) !== 8'hEF) begin
      errors++; $display("FAIL sw_ram got=%h..%h exp=EF..DE", ram_rd(32'h2000), ram_rd(32'h2003));
    end
  endtask

  task automatic test_simultaneous();
    int md = -1, id = -1; logic [31:0] rd = '0, ins = '0;
    preload(32'h10, 8'h80);
    @(negedge clk);
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = MEM_BYTE; mem_addr_i = 32'h10;
    if_req_i = 1'b1; if_addr_i = 32'h100;
    for (int k = 1; k <= 20 && (md < 0 || id < 0); k++) begin
      @(negedge clk);
      if (mem_done_o && md < 0) begin md = k; rd = mem_rdata_o; mem_req_i = 1'b0; end
      if (if_done_o && id < 0) begin id = k; ins = if_inst_o; if_req_i = 1'b0; end
    end
    mem_req_i = 1'b0; if_req_i = 1'b0;
    checks++; if (md != 3) begin errors++; $display("FAIL simul_mem_latency got=C%0d exp=C3", md); end
    checks++; if (rd !== 32'h0000_0080) begin errors++; $display("FAIL simul_lb_data got=%h exp=00000080", rd); end
    checks++; if (id != 10) begin errors++; $display("FAIL simul_if_latency got=C%0d exp=C10", id); end
    checks++; if (ins !== 32'h0010_0513) begin errors++; $display("FAIL simul_if_inst got=%h exp=00100513", ins); end
  endtask

  task automatic test_cancel();
    int id = -1; logic [31:0] ins = '0;
    logic [31:0] exp_w;
    for (int i = 0; i < 4; i++) preload(32'h200 + 32'(i), 8'($urandom));
    exp_w = ref_word(32'h200, 4);
    @(negedge clk);
    if_req_i = 1'b1; if_addr_i = 32'h100;
    for (int k = 1; k <= 16 && id < 0; k++) begin
      @(negedge clk);
      obs_addr[k] = ram_addr_o; obs_wr[k] = ram_wr_o;
      if (if_done_o) begin id = k; ins = if_inst_o; if_req_i = 1'b0; end
      if (k == 2) begin if_cancel_i = 1'b1; if_addr_i = 32'h200; end
      if (k == 3) if_cancel_i = 1'b0;
    end
    if_req_i = 1'b0; if_cancel_i = 1'b0;
    checks++;
    if (obs_addr[4] !== 32'h103 || obs_addr[5] !== 32'h103 || obs_wr[5] !== 1'b0) begin
      errors++; $display("FAIL cancel_bus_completes got C4=%h C5=%h exp 103/103", obs_addr[4], obs_addr[5]);
    end
    checks++; if (id != 13) begin errors++; $display("FAIL cancel_no_done got first done C%0d exp=C13", id); end
    checks++; if (obs_addr[7] !== 32'h0 || obs_addr[8] !== 32'h200) begin
      errors++; $display("FAIL cancel_reaccept got C7=%h C8=%h exp 0/200", obs_addr[7], obs_addr[8]);
    end
    checks++; if (ins !== exp_w) begin errors++; $display("FAIL cancel_new_inst got=%h exp=%h", ins, exp_w); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    for (int i = 0; i < 4; i++) preload(32'h3000 + 32'(i), 8'h11);
    @(negedge clk);
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = MEM_WORD;
    mem_addr_i = 32'h3000; mem_wdata_i = 32'hA1B2_C3D4;
    repeat (3) @(negedge clk);
    rst = 1'b0; mem_req_i = 1'b0;
    #1;
    checks++; if (ram_wr_o !== 1'b0) begin errors++; $display("FAIL rstmid_wr_forced got=%b exp=0", ram_wr_o); end
    @(negedge clk);
    rst = 1'b1;
    checks++; if (ram_addr_o !== 32'h0 || ram_wr_o !== 1'b0) begin
      errors++; $display("FAIL rstmid_idle got addr=%h wr=%b exp 0/0", ram_addr_o, ram_wr_o);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (mem_done_o) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_no_done got=%0d pulses exp=0", seen); end
    ref_mem[32'h3000] = 8'hD4; ref_mem[32'h3001] = 8'hC3;
    checks++;
    if (ram_rd(32'h3000) !== 8'hD4 || ram_rd(32'h3001) !== 8'hC3 || ram_rd(32'h3002) !== 8'h11 || ram_rd(32'h3003) !== 8'h11) begin
      errors++; $display("FAIL rstmid_partial got=%h %h %h %h exp=d4 c3 11 11",
                         ram_rd(32'h3000), ram_rd(32'h3001), ram_rd(32'h3002), ram_rd(32'h3003));
    end
  endtask

  task automatic test_wrap();
    int dc; logic [31:0] d;
    preload(32'hFFFF_FFFF, 8'h5A); preload(32'h0, 8'hC3);
    run_access(1'b0, 1'b0, MEM_HALF, 32'hFFFF_FFFF, 32'h0, dc, d);
    checks++; if (obs_addr[1] !== 32'hFFFF_FFFF || obs_addr[2] !== 32'h0) begin
      errors++; $display("FAIL wrap_addr got=%h,%h exp=ffffffff,00000000", obs_addr[1], obs_addr[2]);
    end
    checks++; if (dc != 4) begin errors++; $display("FAIL wrap_latency got=C%0d exp=C4", dc); end
    checks++; if (d !== 32'h0000_C35A) begin errors++; $display("FAIL wrap_data got=%h exp=0000c35a", d); end
  endtask

  task automatic test_random();
    int dc, n, bad; logic [31:0] d, a, wd, exp_d; bit is_if, we; logic [1:0] sel;
    for (int i = 0; i < 64; i++) preload(32'h4000 + 32'(i), 8'($urandom));
    for (int t = 0; t < 40; t++) begin
      is_if = ($urandom_range(0, 3) == 0);
      we    = is_if ? 1'b0 : 1'($urandom_range(0, 1));
      sel   = is_if ? MEM_WORD : 2'($urandom_range(0, 2));
      a     = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                          : 32'h4000 + 32'($urandom_range(0, 59));
      wd    = $urandom;
      n     = nbytes(sel);
      exp_d = ref_word(a, n);
      run_access(is_if, we, sel, a, wd, dc, d);
      bad = 0;
      for (int k = 1; k <= n; k++) begin
        if (obs_addr[k] !== a + 32'(k - 1) || obs_wr[k] !== we) bad++;
        if (we && obs_dout[k] !== wd[8*(k-1) +: 8]) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL rand_bus t=%0d addr=%h n=%0d we=%b got %0d bad cycles exp 0", t, a, n, we, bad); end
      checks++; if (dc != (we ? n + 1 : n + 2)) begin
        errors++; $display("FAIL rand_latency t=%0d got=C%0d exp=C%0d", t, dc, we ? n + 1 : n + 2);
      end
      if (we) begin
        for (int k = 0; k < n; k++) ref_mem[a + 32'(k)] = wd[8*k +: 8];
      end else begin
        checks++; if (d !== exp_d) begin errors++; $display("FAIL rand_rdata t=%0d addr=%h n=%0d got=%h exp=%h", t, a, n, d, exp_d); end
      end
    end
    bad = 0;
    foreach (ref_mem[x]) if (ram_rd(x) !== ref_mem[x]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rand_ram_image got=%0d differing bytes exp=0", bad); end
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b1;
    test_fetch();
    test_sw();
    test_simultaneous();
    test_cancel();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial memory controller placed directly downstream of the MEM stage and the IF stage.
- Arbitrates instruction fetches (always 4 bytes) and data loads/stores (1/2/4 bytes) onto a single 8-bit RAM port.
- The RAM has 1-cycle read latency.
- Returns assembled little-endian words and one-cycle done pulses, so upstream stages can release their stall requests.

Parameters:
- ADDR_W, 32, width of all byte addresses (matches MemAddrBus).

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- rst  in  1  reset: synchronous, active-low.
- if_req_i  in  1  fetch request; held high until if_done_o.
- if_addr_i  in  ADDR_W  fetch base address.
- if_cancel_i  in  1  branch flush; kills the pending or in-flight fetch.
- if_done_o  out  1  one-cycle pulse: if_inst_o is valid.
- if_inst_o  out  32  fetched word, little-endian.
- mem_req_i  in  1  data request; held high until mem_done_o.
- mem_we_i  in  1  1 = store, 0 = load.
- mem_sel_i  in  2  MEM_BYTE / MEM_HALF / MEM_WORD.
- mem_addr_i  in  ADDR_W  data base address.
- mem_wdata_i  in  32  store data (byte 0 = bits 7:0).
- mem_done_o  out  1  one-cycle pulse: access complete.
- mem_rdata_o  out  32  load data, zero-extended; MEM stage applies sign extension.
- ram_addr_o  out  ADDR_W  RAM byte address.
- ram_wr_o  out  1  RAM write strobe.
- ram_dout_o  out  8  RAM write byte.
- ram_din_i  in  8  RAM read byte; valid the cycle after its address was driven.

Behaviour:
- Reset (rst low at an edge):
  - state IDLE, counter 0.
  - if_done_o, mem_done_o, ram_wr_o = 0; if_inst_o, mem_rdata_o, ram_addr_o, ram_dout_o = 0.
  - ram_wr_o is forced to 0 combinationally whenever rst is low.
  - Reset mid-transaction aborts it: no done pulse, and partial data is discarded.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Samples requests each cycle.
  - If both mem_req_i and if_req_i are high, MEM wins.
  - Acceptance latches owner, base address, length n (1/2/4), direction and write data; then go to BUSY with cnt = 0.
  - A fetch with if_cancel_i high in the same cycle is not accepted.
- BUSY, read:
  - For cnt < n: ram_addr_o = base + cnt, ram_wr_o = 0.
  - For cnt = n: ram_addr_o holds base + n - 1, ram_wr_o = 0.
  - At each edge with cnt >= 1, ram_din_i is stored into byte lane cnt-1. Bytes not covered by n read as 0.
  - After the edge that stores lane n-1 (cnt = n), go to DONE.
- BUSY, write:
  - ram_addr_o = base + cnt, ram_dout_o = wdata byte cnt, ram_wr_o = 1.
  - After the edge at cnt = n-1, go to DONE.
- Address arithmetic is ADDR_W-bit modulo. base + cnt wraps at 2^ADDR_W; this is not an error.
- Latency: let C0 be the cycle in which a request is accepted in IDLE.
  - Read of n bytes: BUSY occupies C1..C(n+1); done pulse in C(n+2). LW/fetch = C6, LB = C3.
  - Write of n bytes: BUSY occupies C1..Cn; done pulse in C(n+1). SW = C5, SB = C2.
- DONE:
  - Lasts exactly one cycle, then IDLE.
  - Asserts the owner's done_o; rdata/inst outputs are registered and hold until the next completion of that owner.
  - No request is accepted in the DONE cycle, because the requester drops req during it.
- if_cancel_i:
  - In BUSY for a fetch, the bus sequence still completes, but DONE asserts no if_done_o.
  - A flag set by cancel clears on return to IDLE.
  - Cancel has no effect on a MEM-owned transaction.
- No preemption: a waiting mem_req_i waits for the in-flight fetch to finish.
- ram_wr_o is 0 in IDLE and DONE, and during all reads.
- A stray req deasserting while BUSY is ignored; the transaction completes.

Decomposition:
- Shared package/defines.v holds:
  - MEM_BYTE/MEM_HALF/MEM_WORD encodings.
  - State encodings MC_IDLE/MC_BUSY/MC_DONE.
  - MemAddrBus, MemDataBus, ZeroWord.
- One natural sub-module: mem_ctrl_lane_asm, the byte-lane assembler that stores ram_din_i into lane cnt-1 and zero-fills.

Test Plan:
- Fetch: if_req_i with if_addr_i=0x100, RAM[0x100..0x103] = 13,05,10,00.
  - Addresses 0x100..0x103 driven in C1..C4.
  - if_done_o in C6 with if_inst_o = 0x00100513.
- SW: mem_addr_i=0x2000, wdata=0xDEADBEEF.
  - ram_wr_o=1 in C1..C4 with bytes EF, BE, AD, DE at 0x2000..0x2003.
  - mem_done_o in C5; ram_wr_o=0 in C5.
- Simultaneous requests: if_req_i and mem_req_i (LB at 0x10, RAM = 0x80) rise together.
  - mem_done_o in C3 with mem_rdata_o = 0x00000080.
  - Fetch then accepted in C4; if_done_o in C10.
- Cancel: if_cancel_i pulses in C2 of a fetch.
  - Bus completes through C5.
  - No if_done_o in C6; a new request is accepted in C7.
- Reset: rst low during C3 of an SW.
  - ram_wr_o=0 in that cycle.
  - IDLE after the edge; no mem_done_o; only bytes 0..1 were written.
- Wrap: LH at 0xFFFFFFFF.
  - Addresses 0xFFFFFFFF then 0x00000000.
  - mem_done_o in C4.
